// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and widths for the SAR conversion engine
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        BIT    = 2'd2,
        DONE   = 2'd3
    } sar_state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sar_adc_logic_if.sv
// rtl/sar_adc_logic_if.sv - sequencer handshake and comparator/DAC signals of the SAR engine
interface sar_adc_logic_if #(
    parameter int N = 8
);
    logic         adc_convert;
    logic         comp_out;
    logic         sample;
    logic [N-1:0] dac_code;
    logic [N-1:0] adc_data;
    logic         adc_done;

    modport master (
        output adc_convert,
        output comp_out,
        input  sample,
        input  dac_code,
        input  adc_data,
        input  adc_done
    );

    modport slave (
        input  adc_convert,
        input  comp_out,
        output sample,
        output dac_code,
        output adc_data,
        output adc_done
    );
endinterface

// File: rtl/sar_trial_reg.sv
// rtl/sar_trial_reg.sv - result and trial-mask registers of the binary search
module sar_trial_reg
    import sar_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         clear,
    input  logic         load,
    input  logic         step,
    input  logic         comp,
    output logic [N-1:0] code,
    output logic         last
);

    logic [N-1:0] result_q, result_d;
    logic [N-1:0] mask_q, mask_d;

    always_comb begin
        result_d = result_q;
        mask_d   = mask_q;
        if (clear) begin
            result_d = '0;
            mask_d   = '0;
        end else if (load) begin
            result_d = '0;
            mask_d   = {1'b1, {(N-1){1'b0}}};
        end else if (step) begin
            result_d = comp ? (result_q | mask_q) : result_q;
            mask_d   = mask_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            result_q <= '0;
            mask_q   <= '0;
        end else begin
            result_q <= result_d;
            mask_q   <= mask_d;
        end
    end

    // Once the mask shifts out after the LSB trial, code is the settled result.
    assign code = result_q | mask_q;
    assign last = (mask_q == N'(1));

endmodule

// File: rtl/sar_adc_logic.sv
// rtl/sar_adc_logic.sv - SAR conversion FSM, sample counter and output registers
module sar_adc_logic
    import sar_pkg::*;
#(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           resetb,
    sar_adc_logic_if.slave bus
);

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_q, sample_d;
    logic             done_q, done_d;
    logic [N-1:0]     data_q, data_d;
    logic             trial_clear, trial_load, trial_step;
    logic [N-1:0]     code;
    logic             last;

    sar_trial_reg #(.N(N)) u_trial (
        .clk    (clk),
        .resetb (resetb),
        .clear  (trial_clear),
        .load   (trial_load),
        .step   (trial_step),
        .comp   (bus.comp_out),
        .code   (code),
        .last   (last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        done_d      = done_q;
        data_d      = data_q;
        trial_clear = 1'b0;
        trial_load  = 1'b0;
        trial_step  = 1'b0;
        case (state_q)
            IDLE: begin
                sample_d = 1'b0;
                done_d   = 1'b0;
                if (bus.adc_convert) begin
                    state_d  = SAMPLE;
                    sample_d = 1'b1;
                    cnt_d    = CNT_W'(SAMPLE_CYCLES - 1);
                end
            end
            SAMPLE: begin
                if (!bus.adc_convert) begin
                    state_d     = IDLE;
                    sample_d    = 1'b0;
                    trial_clear = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d    = BIT;
                    sample_d   = 1'b0;
                    trial_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BIT: begin
                if (!bus.adc_convert) begin
                    state_d     = IDLE;
                    trial_clear = 1'b1;
                end else begin
                    trial_step = 1'b1;
                    // On the LSB trial the mask is 1, so the final result is the
                    // upper code bits with the comparator decision in bit 0.
                    if (last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        data_d  = {code[N-1:1], bus.comp_out};
                    end
                end
            end
            DONE: begin
                if (!bus.adc_convert) begin
                    state_d     = IDLE;
                    done_d      = 1'b0;
                    trial_clear = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                sample_d    = 1'b0;
                done_d      = 1'b0;
                trial_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            done_q   <= done_d;
            data_q   <= data_d;
        end
    end

    assign bus.sample   = sample_q;
    assign bus.adc_done = done_q;
    assign bus.adc_data = data_q;
    assign bus.dac_code = code;

endmodule
